fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch sequencer for the femtoRV32 core.
- Sits upstream of the control unit and decoder. It fetches the instruction whose opcode and funct3 feed the control unit.
- It also consumes the control unit's PC-selection and halt outputs to compute and commit the next PC.
- Talks to instruction memory through a simple request/ready handshake, so memories with wait states are supported.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction register value when no valid instruction is held (ADDI x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_sel  input  2  from control unit: 00=PC+4, 01=PC+imm, 10=rs1+imm, 11=halt.
- branch_taken  input  1  from jump/branch resolution; qualifies pc_sel=01 (high for taken branch or JAL).
- end_program  input  1  halt request from control unit.
- imm  input  32  sign-extended immediate from immediate generator.
- rs1_data  input  32  register-file rs1 read data (JALR base).
- retire  input  1  execute stage accepts current instruction; commits next PC this cycle.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  instruction memory word address (= pc).
- imem_rdata  input  32  instruction memory read data, valid when imem_ready=1.
- imem_ready  input  1  memory response strobe.
- instr  output  32  held instruction to decode; bits [6:2] drive control unit Opcode.
- instr_valid  output  1  instr is valid and awaiting retire.
- pc  output  32  address of held/fetching instruction.
- pc_plus4  output  32  pc+4, combinational; used for JAL/JALR writeback.
- halted  output  1  core stopped.
- misaligned  output  1  fetch-target misalignment flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge, from any state, including mid-WAIT):
  - pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, halted=0, misaligned=0, state=FETCH.
  - imem_req is low in the reset cycle and goes high the first cycle after reset deasserts.
- States: FETCH, EXEC, HALT. FETCH covers wait states; no separate state is needed.
- FETCH:
  - imem_req=1, imem_addr=pc. Address is held stable until imem_ready.
  - imem_ready=1 at edge: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - imem_ready=0: stay in FETCH. Unbounded wait; no timeout.
- EXEC:
  - imem_req=0, instr_valid=1, instr and pc stable.
  - retire=0: hold indefinitely.
  - retire=1 and (end_program=1 or pc_sel=11): go to HALT. pc unchanged (points at halting instruction), instr_valid<=0, instr<=NOP_INSTR.
  - retire=1 otherwise: pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc (all arithmetic modulo 2^32, wrap silently):
  - 00: pc+4.
  - 01: branch_taken ? pc+imm : pc+4.
  - 10: (rs1_data+imm) & ~32'h1.
  - 11: not reached (halt).
- HALT:
  - Absorbing until rst.
  - halted=1, imem_req=0, instr_valid=0; retire, imem_ready and all other inputs ignored.
- retire outside EXEC is ignored. imem_ready outside FETCH is ignored; no capture.
- end_program takes priority over pc_sel when both indicate activity.
- Minimum throughput: 2 cycles per instruction (FETCH with same-cycle ready, EXEC with same-cycle retire).
- Memory latency N cycles adds N cycles in FETCH.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: at retire, if next_pc[1:0]!=0, enter HALT with misaligned<=1 and pc<=offending next_pc. No fetch is issued to that address. misaligned clears only on rst.
- Undefined:
  - next_pc[1] is cleared in addition to the JALR bit-0 clear, so every fetch is word-aligned.
  - misaligned is tied to 0.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst for 2 cycles; imem_ready=1 every cycle; pc_sel=00; retire=1 in EXEC.
  - Required: imem_addr sequence 0,4,8,C; instr_valid high every second cycle; halted=0.
- Branch resolution:
  - At pc=0x10 with imm=0xFFFFFFF0: pc_sel=01, branch_taken=1 -> next pc=0x00.
  - At pc=0x10 with imm=0xFFFFFFF0: pc_sel=01, branch_taken=0 -> next pc=0x14.
  - pc=0xFFFFFFFC, pc_sel=00 -> next pc=0x00000000 (wrap).
- JALR: rs1_data=0x1001, imm=0x4, pc_sel=10 -> next pc=0x1004; pc_plus4 equals old pc+4 during EXEC.
- Wait states and reset mid-wait:
  - imem_ready low for 3 cycles -> imem_req and imem_addr stable all 3 cycles, instr captured on 4th.
  - rst asserted during wait -> pc=RESET_PC, imem_req=0 in reset cycle, instr_valid=0.
- Halt: pc=0x20, end_program=1, pc_sel=11, retire=1 -> halted=1 next cycle, pc=0x20, imem_req=0 for 10+ cycles despite imem_ready/retire toggling; rst restores fetch.
- FETCH_MISALIGN_TRAP_EN: pc=0x8, imm=0x2, pc_sel=01, branch_taken=1, retire=1:
  - Defined: misaligned=1, halted=1, pc=0xA, no request to 0xA.
  - Undefined: next fetch address=0x8, misaligned=0.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Instruction-memory read port: request/address out, data/ready back.
interface fetch_pc_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  ready
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// femtoRV32 program counter and instruction-fetch sequencer (FETCH/EXEC/HALT).
// Optional macro FETCH_MISALIGN_TRAP_EN: halt with o_misaligned on an unaligned next PC.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_pc_sel,
    input  logic        i_branch_taken,
    input  logic        i_end_program,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_data,
    input  logic        i_retire,
    fetch_pc_if.master  imem,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_halted,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic        r_instr_valid;
    logic        w_instr_valid_nxt;
    logic        r_req;
    logic        r_halted;
    logic        w_misalign_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_mis_trap;
    logic        w_halt_req;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_halt_req = i_end_program | (i_pc_sel == 2'b11);

    // Raw redirect target selected by the control unit
    always_comb begin
        w_target = w_pc_plus4;
        case (i_pc_sel)
            2'b00: w_target = w_pc_plus4;
            2'b01: begin
                if (i_branch_taken) begin
                    w_target = r_pc + i_imm;
                end else begin
                    w_target = w_pc_plus4;
                end
            end
            2'b10:   w_target = (i_rs1_data + i_imm) & ~32'h0000_0001;
            default: w_target = w_pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_next_pc  = w_target;
    assign w_mis_trap = (w_target[1:0] != 2'b00);
`else
    // Without the trap every fetch is forced onto a word boundary
    assign w_next_pc  = w_target & ~32'h0000_0003;
    assign w_mis_trap = 1'b0;
`endif

    // Next-state and next-register computation
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_misalign_nxt    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // r_req gates capture so the post-reset idle cycle ignores ready
                if (r_req && imem.ready) begin
                    w_instr_nxt       = imem.rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (!i_retire) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_halt_req) begin
                    w_instr_nxt       = NOP_INSTR;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = ST_HALT;
                end else if (w_mis_trap) begin
                    w_pc_nxt          = w_next_pc;
                    w_instr_nxt       = NOP_INSTR;
                    w_instr_valid_nxt = 1'b0;
                    w_misalign_nxt    = 1'b1;
                    w_state_nxt       = ST_HALT;
                end else begin
                    w_pc_nxt          = w_next_pc;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt       = ST_FETCH;
                w_instr_nxt       = NOP_INSTR;
                w_instr_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_req         <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_req         <= (w_state_nxt == ST_FETCH);
            r_halted      <= (w_state_nxt == ST_HALT);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misaligned;

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else if (w_misalign_nxt) begin
            r_misaligned <= 1'b1;
        end else begin
            r_misaligned <= r_misaligned;
        end
    end

    assign o_misaligned = r_misaligned;
`else
    logic w_misalign_unused;
    assign w_misalign_unused = w_misalign_nxt;
    assign o_misaligned      = 1'b0 & w_misalign_unused;
`endif

    assign imem.req      = r_req;
    assign imem.addr     = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized run
// against a behavioural PC/fetch model.
module tb_fetch_pc_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic        branch_taken = 1'b0;
    logic        end_program = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic        retire = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misaligned;

    fetch_pc_if u_if ();

    fetch_pc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_pc_sel       (pc_sel),
        .i_branch_taken (branch_taken),
        .i_end_program  (end_program),
        .i_imm          (imm),
        .i_rs1_data     (rs1_data),
        .i_retire       (retire),
        .imem           (u_if),
        .o_instr        (instr),
        .o_instr_valid  (instr_valid),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4),
        .o_halted       (halted),
        .o_misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: architectural view of the sequencer
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_holding;
    logic        m_stopped;
    logic        m_mis;
    logic        m_fresh;
    logic        m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (m_known) begin
            chk("imem_req",    {31'd0, u_if.req},
                {31'd0, (!m_stopped && !m_holding && !m_fresh)});
            chk("imem_addr",   u_if.addr, m_pc);
            chk("pc",          pc, m_pc);
            chk("pc_plus4",    pc_plus4, m_pc + 32'd4);
            chk("instr",       instr, m_instr);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
            chk("halted",      {31'd0, halted}, {31'd0, m_stopped});
            chk("misaligned",  {31'd0, misaligned}, {31'd0, m_mis});
        end
    endtask

    task automatic model_update(input logic r, input logic [1:0] sel, input logic bt,
                                input logic ep, input logic [31:0] im, input logic [31:0] rs,
                                input logic ret, input logic [31:0] rd, input logic rdy);
        logic [31:0] tgt;
        if (r) begin
            m_pc = RST_PC; m_instr = NOP; m_holding = 1'b0;
            m_stopped = 1'b0; m_mis = 1'b0; m_fresh = 1'b1; m_known = 1'b1;
        end else if (!m_known || m_stopped) begin
            m_fresh = 1'b0;
        end else if (m_holding) begin
            if (ret) begin
                if (ep || sel == 2'b11) begin
                    m_stopped = 1'b1; m_holding = 1'b0; m_instr = NOP;
                end else begin
                    if (sel == 2'b01 && bt)  tgt = m_pc + im;
                    else if (sel == 2'b10)   tgt = (rs + im) & ~32'h1;
                    else                     tgt = m_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (tgt % 4 != 0) begin
                        m_stopped = 1'b1; m_mis = 1'b1; m_instr = NOP;
                    end
                    m_pc = tgt;
`else
                    m_pc = tgt - (tgt % 4);
`endif
                    m_holding = 1'b0;
                end
            end
        end else begin
            if (!m_fresh && rdy) begin
                m_instr = rd; m_holding = 1'b1;
            end
            m_fresh = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic [1:0] sel, input logic bt, input logic ep,
                        input logic [31:0] im, input logic [31:0] rs, input logic ret,
                        input logic [31:0] rd, input logic rdy);
        rst = r; pc_sel = sel; branch_taken = bt; end_program = ep;
        imm = im; rs1_data = rs; retire = ret;
        u_if.rdata = rd; u_if.ready = rdy;
        model_update(r, sel, bt, ep, im, rs, ret, rd, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_rst();
        step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_fetch(input logic [31:0] data);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, data, 1'b1);
    endtask

    task automatic do_retire(input logic [1:0] sel, input logic bt, input logic ep,
                             input logic [31:0] im, input logic [31:0] rs);
        step(1'b0, sel, bt, ep, im, rs, 1'b1, 32'h0, 1'b1);
    endtask

    initial begin
        u_if.rdata = 32'h0;
        u_if.ready = 1'b0;
        @(negedge clk);

        // Reset and sequential fetch
        do_rst();
        do_rst();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, u_if.req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", u_if.addr, 32'(k * 4));
            chk("seq_req", {31'd0, u_if.req}, 32'd1);
            do_fetch(32'h1000_0000 + 32'(k));
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            do_retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("seq_valid_lo", {31'd0, instr_valid}, 32'd0);
            chk("seq_halted", {31'd0, halted}, 32'd0);
        end
        chk("seq_pc10", pc, 32'h10);

        // Branch taken / not taken from 0x10
        do_fetch(32'h0000_0063);
        do_retire(2'b01, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        chk("br_taken", pc, 32'h0);
        do_fetch(32'h0000_006F);
        do_retire(2'b01, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("br_back", pc, 32'h10);
        do_fetch(32'h0000_0063);
        do_retire(2'b01, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        chk("br_not", pc, 32'h14);

        // Wrap at top of address space
        do_fetch(32'h0000_0067);
        do_retire(2'b10, 1'b0, 1'b0, 32'h4, 32'hFFFF_FFF9);
        chk("to_top", pc, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0013);
        chk("top_plus4", pc_plus4, 32'h0);
        do_retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap", pc, 32'h0);

        // JALR
        do_fetch(32'h0000_0067);
        chk("jalr_plus4", pc_plus4, 32'h4);
        do_retire(2'b10, 1'b0, 1'b0, 32'h4, 32'h1001);
        chk("jalr_pc", pc, 32'h1004);

        // Wait states then capture
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b0);
            chk("wait_req", {31'd0, u_if.req}, 32'd1);
            chk("wait_addr", u_if.addr, 32'h1004);
        end
        do_fetch(32'hDEAD_BEEF);
        chk("wait_instr", instr, 32'hDEAD_BEEF);

        // Reset during a wait
        do_retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_rst();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_req", {31'd0, u_if.req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);

        // Halt at 0x20
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_fetch(32'h0000_006F);
        do_retire(2'b01, 1'b1, 1'b0, 32'h20, 32'h0);
        do_fetch(32'h0000_0073);
        do_retire(2'b11, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h20);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom,
                 $urandom, 1'(k), $urandom, 1'(~k));
            chk("halt_req", {31'd0, u_if.req}, 32'd0);
        end
        do_rst();
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("unhalt_req", {31'd0, u_if.req}, 32'd1);

        // Misaligned branch target
        do_fetch(32'h0000_006F);
        do_retire(2'b01, 1'b1, 1'b0, 32'h8, 32'h0);
        do_fetch(32'h0000_0063);
        do_retire(2'b01, 1'b1, 1'b0, 32'h2, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_halt", {31'd0, halted}, 32'd1);
        chk("mis_pc", pc, 32'hA);
        chk("mis_req", {31'd0, u_if.req}, 32'd0);
`else
        chk("mis_flag", {31'd0, misaligned}, 32'd0);
        chk("mis_addr", u_if.addr, 32'h8);
        chk("mis_req", {31'd0, u_if.req}, 32'd1);
`endif

        // Randomized run
        do_rst();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] sel;
            sel = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step(($urandom_range(0, 39) == 0), sel, 1'($urandom), ($urandom_range(0, 31) == 0),
                 $urandom & ~32'h1, $urandom, 1'($urandom), $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
